pcram_loader: RTL and testbench
===============================

// Module: pcram_loader
// PURPOSE
//  Load sequencer for the program RAM. Accepts a framed word stream (start addr, length, data, checksum) over valid/ready.
//  Writes data words through the RAM programmer port, then reads them back through the instruction port to verify.
//  Owns the instruction-address mux and holds all cores halted until a verified program is present.
//  Sits between host/UART link and the program RAM, beside the core cluster.
// PARAMETERS
//  CounterBits  6  program RAM address width; depth = 2**CounterBits
//  FetchBits    8  program word width; must be >= CounterBits
// PORTS
//  CLK                    in   1            system clock, rising edge
//  RSTn                   in   1            asynchronous reset, active low
//  Loader_Start           in   1            1-cycle pulse: begin a frame (honoured in IDLE only)
//  Loader_Abort           in   1            abandon current frame
//  Loader_InData          in   FetchBits    stream word
//  Loader_InValid         in   1            stream word valid
//  Loader_InReady         out  1            loader accepts word this cycle
//  Loader_Busy            out  1            state != IDLE
//  Loader_Done            out  1            1-cycle pulse: verified load complete
//  Loader_Error           out  1            sticky: checksum/readback mismatch or abort
//  Cores_Halt             out  1            hold all cores
//  Core_InstructionAddr   in   CounterBits  fetch address from cores
//  PCRam_WE               out  1            RAM write enable
//  PCRam_EN               out  1            RAM enable
//  PCRam_ProgrammerAddr   out  CounterBits  RAM write address
//  PCRam_ProgrammerData   out  FetchBits    RAM write data
//  PCRam_InstructionAddr  out  CounterBits  RAM read address (mux)
//  PCRam_OutputData       in   FetchBits    RAM async read data
// BEHAVIOUR
//  Reset: state IDLE; ProgValid=0 so Cores_Halt=1; Done=0, Error=0, pointers/sums/len=0; WE=EN=0.
//  Cores_Halt = ~ProgValid. ProgValid cleared on accepted Start, set only on entry to DONE.
//  Handshake: word accepted on edge where InValid & InReady. InReady=1 in HDR_ADDR, HDR_LEN, DATA, CSUM; else 0.
//  FSM:
//   IDLE    : Start -> HDR_ADDR; clears Error, ProgValid, sums.
//   HDR_ADDR: accept -> base=InData[CounterBits-1:0], wptr=base -> HDR_LEN.
//   HDR_LEN : accept -> len=InData[CounterBits-1:0] (words = len+1), cnt=0 -> DATA.
//   DATA    : per accept: write, wsum+=InData, wptr+=1, cnt+=1; after word len+1 -> CSUM.
//   CSUM    : accept -> csum=InData; rptr=base, cnt=0, rsum=0 -> VERIFY.
//   VERIFY  : one word/cycle: rsum+=PCRam_OutputData, rptr+=1; after len+1 cycles -> CHECK.
//   CHECK   : (wsum==csum && rsum==csum) ? DONE : ERROR.
//   DONE    : Done=1 for this cycle, ProgValid=1 -> IDLE.
//   ERROR   : Error=1 -> IDLE; Error held until next accepted Start.
//  Write: combinational in DATA: PCRam_WE=PCRam_EN=InValid; ProgrammerAddr=wptr; ProgrammerData=InData.
//   RAM captures on the same edge as the handshake. WE=EN=0 in all other states.
//  Read mux: PCRam_InstructionAddr = rptr in VERIFY, else Core_InstructionAddr.
//  Arithmetic: all sums mod 2**FetchBits. wptr/rptr wrap mod 2**CounterBits (base=62, len=3 -> 62,63,0,1).
//  Latency: frame of len+4 words; DONE pulse len+2 cycles after checksum accept (VERIFY len+1, CHECK 1).
//  Abort: in any non-IDLE state -> ERROR next edge; in-flight DATA word not written that cycle; ProgValid stays 0.
//  Abort has priority over handshake. Start outside IDLE ignored. Abort in IDLE ignored.
//  Async reset mid-frame: immediate IDLE, Halt=1, partial RAM contents left as written.
//  InValid low stalls any receiving state indefinitely (no timeout).
// TESTING
//  Reset -> Halt=1, Busy=0, WE=0, Done=0, Error=0; InstructionAddr follows Core_InstructionAddr.
//  Start; stream 0x05,0x02,0x11,0x22,0x33,0x66 -> RAM[5..7]=11,22,33; 3-cycle VERIFY; Done pulse; Halt=0.
//  Frame base 0x3E, len 0x03, data 01,02,03,04, csum 0x0A -> writes at 62,63,0,1 (wrap); Done.
//  Same as case 2 with csum 0x67 -> no Done; Error=1 sticky; Halt=1; next Start clears Error.
//  Abort after 2nd data word with InValid=1 -> only 1st data word written; Error=1; Busy=0 after 2 edges.
//  InValid gaps of 0-5 random cycles in case 2 -> same RAM contents and Done; Start during DATA ignored.

Source files
------------

// File: rtl/pcram_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : pcram_loader_if
// Purpose  : valid/ready word stream from the host link into the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface pcram_loader_if #(
   parameter int FetchBits = 8
) ();
   logic [FetchBits-1:0] Loader_InData;
   logic                 Loader_InValid;
   logic                 Loader_InReady;

   modport master (
      output Loader_InData,
      output Loader_InValid,
      input  Loader_InReady
   );

   modport slave (
      input  Loader_InData,
      input  Loader_InValid,
      output Loader_InReady
   );
endinterface
`default_nettype wire

// File: rtl/pcram_loader.sv
`default_nettype none
// ============================================================================
// Module   : pcram_loader
// Purpose  : receives a framed program, writes it into the program RAM,
//            reads it back to verify, and halts the cores until it is valid.
// Revision : 1.0 - initial release
// ============================================================================
module pcram_loader #(
   parameter int CounterBits = 6,
   parameter int FetchBits   = 8
) (
   input  wire                    CLK,
   input  wire                    RSTn,
   pcram_loader_if.slave          stream,
   input  wire                    Loader_Start,
   input  wire                    Loader_Abort,
   output logic                   Loader_Busy,
   output logic                   Loader_Done,
   output logic                   Loader_Error,
   output logic                   Cores_Halt,
   input  wire  [CounterBits-1:0] Core_InstructionAddr,
   output logic                   PCRam_WE,
   output logic                   PCRam_EN,
   output logic [CounterBits-1:0] PCRam_ProgrammerAddr,
   output logic [FetchBits-1:0]   PCRam_ProgrammerData,
   output logic [CounterBits-1:0] PCRam_InstructionAddr,
   input  wire  [FetchBits-1:0]   PCRam_OutputData
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_HDR_ADDR = 4'd1,
      S_HDR_LEN  = 4'd2,
      S_DATA     = 4'd3,
      S_CSUM     = 4'd4,
      S_VERIFY   = 4'd5,
      S_CHECK    = 4'd6,
      S_DONE     = 4'd7,
      S_ERROR    = 4'd8
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic [CounterBits-1:0] r_base;
   logic [CounterBits-1:0] r_len;
   logic [CounterBits-1:0] r_cnt;
   logic [CounterBits-1:0] r_wptr;
   logic [CounterBits-1:0] r_rptr;
   logic [FetchBits-1:0]   r_wsum;
   logic [FetchBits-1:0]   r_rsum;
   logic [FetchBits-1:0]   r_csum;
   logic                   r_prog_valid;
   logic                   r_error;

   logic                   w_rx;
   logic                   w_accept;
   logic                   w_last;
   logic                   w_sums_ok;

   // Abort masks ready so an in-flight word is neither accepted nor written.
   assign w_rx      = (r_state == S_HDR_ADDR) || (r_state == S_HDR_LEN) ||
                      (r_state == S_DATA)     || (r_state == S_CSUM);
   assign w_accept  = stream.Loader_InValid && stream.Loader_InReady;
   assign w_last    = (r_cnt == r_len);
   assign w_sums_ok = (r_wsum == r_csum) && (r_rsum == r_csum);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (Loader_Start) w_next = S_HDR_ADDR;
         S_HDR_ADDR: if (w_accept) w_next = S_HDR_LEN;
         S_HDR_LEN:  if (w_accept) w_next = S_DATA;
         S_DATA:     if (w_accept && w_last) w_next = S_CSUM;
         S_CSUM:     if (w_accept) w_next = S_VERIFY;
         S_VERIFY:   if (w_last) w_next = S_CHECK;
         S_CHECK:    w_next = w_sums_ok ? S_DONE : S_ERROR;
         S_DONE:     w_next = S_IDLE;
         S_ERROR:    w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
      if (Loader_Abort && (r_state != S_IDLE) && (r_state != S_ERROR))
         w_next = S_ERROR;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_base       <= '0;
         r_len        <= '0;
         r_cnt        <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_wsum       <= '0;
         r_rsum       <= '0;
         r_csum       <= '0;
         r_prog_valid <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Loader_Start) begin
                  r_error      <= 1'b0;
                  r_prog_valid <= 1'b0;
                  r_wsum       <= '0;
                  r_rsum       <= '0;
               end
            end
            S_HDR_ADDR: begin
               if (w_accept) begin
                  r_base <= stream.Loader_InData[CounterBits-1:0];
                  r_wptr <= stream.Loader_InData[CounterBits-1:0];
               end
            end
            S_HDR_LEN: begin
               if (w_accept) begin
                  r_len <= stream.Loader_InData[CounterBits-1:0];
                  r_cnt <= '0;
               end
            end
            S_DATA: begin
               if (w_accept) begin
                  r_wsum <= r_wsum + stream.Loader_InData;
                  r_wptr <= r_wptr + 1'b1;
                  r_cnt  <= r_cnt + 1'b1;
               end
            end
            S_CSUM: begin
               if (w_accept) begin
                  r_csum <= stream.Loader_InData;
                  r_rptr <= r_base;
                  r_cnt  <= '0;
                  r_rsum <= '0;
               end
            end
            S_VERIFY: begin
               r_rsum <= r_rsum + PCRam_OutputData;
               r_rptr <= r_rptr + 1'b1;
               r_cnt  <= r_cnt + 1'b1;
            end
            default: ;
         endcase
         if ((r_state == S_CHECK) && (w_next == S_DONE))
            r_prog_valid <= 1'b1;
         if ((w_next == S_ERROR) && (r_state != S_ERROR))
            r_error <= 1'b1;
      end
   end

   assign stream.Loader_InReady = w_rx && !Loader_Abort;
   assign Loader_Busy           = (r_state != S_IDLE);
   assign Loader_Done           = (r_state == S_DONE);
   assign Loader_Error          = r_error;
   assign Cores_Halt            = !r_prog_valid;

   assign PCRam_WE              = (r_state == S_DATA) && w_accept;
   assign PCRam_EN              = (r_state == S_DATA) && w_accept;
   assign PCRam_ProgrammerAddr  = r_wptr;
   assign PCRam_ProgrammerData  = stream.Loader_InData;
   assign PCRam_InstructionAddr = (r_state == S_VERIFY) ? r_rptr : Core_InstructionAddr;

endmodule
`default_nettype wire

// File: tb/tb_pcram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcram_loader
// Purpose  : self-checking bench for pcram_loader with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcram_loader;
   localparam int CB = 6;
   localparam int FB = 8;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic          Loader_Start = 1'b0;
   logic          Loader_Abort = 1'b0;
   logic          Loader_Busy, Loader_Done, Loader_Error, Cores_Halt;
   logic [CB-1:0] Core_InstructionAddr = '0;
   logic          PCRam_WE, PCRam_EN;
   logic [CB-1:0] PCRam_ProgrammerAddr, PCRam_InstructionAddr;
   logic [FB-1:0] PCRam_ProgrammerData, PCRam_OutputData;

   pcram_loader_if #(.FetchBits(FB)) stream_if ();

   pcram_loader #(.CounterBits(CB), .FetchBits(FB)) dut (
      .CLK                  (CLK),
      .RSTn                 (RSTn),
      .stream               (stream_if),
      .Loader_Start         (Loader_Start),
      .Loader_Abort         (Loader_Abort),
      .Loader_Busy          (Loader_Busy),
      .Loader_Done          (Loader_Done),
      .Loader_Error         (Loader_Error),
      .Cores_Halt           (Cores_Halt),
      .Core_InstructionAddr (Core_InstructionAddr),
      .PCRam_WE             (PCRam_WE),
      .PCRam_EN             (PCRam_EN),
      .PCRam_ProgrammerAddr (PCRam_ProgrammerAddr),
      .PCRam_ProgrammerData (PCRam_ProgrammerData),
      .PCRam_InstructionAddr(PCRam_InstructionAddr),
      .PCRam_OutputData     (PCRam_OutputData)
   );

   always #5 CLK = ~CLK;

   // Program RAM: synchronous write, asynchronous read.
   logic [FB-1:0] mem [0:(1<<CB)-1];
   int            wr_count = 0;
   always @(posedge CLK) begin
      if (PCRam_WE && PCRam_EN) begin
         mem[PCRam_ProgrammerAddr] <= PCRam_ProgrammerData;
         wr_count                  <= wr_count + 1;
      end
   end
   assign PCRam_OutputData = mem[PCRam_InstructionAddr];

   typedef struct {
      logic [CB-1:0]      base;
      logic [CB-1:0]      len;
      logic [7:0][FB-1:0] data;
      logic [FB-1:0]      csum;
      bit                 ok;
   } vec_t;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [FB-1:0] d, input int gap);
      int to;
      stream_if.Loader_InValid = 1'b0;
      repeat (gap) tick();
      stream_if.Loader_InValid = 1'b1;
      stream_if.Loader_InData  = d;
      to = 0;
      while (!stream_if.Loader_InReady && to < 50) begin
         tick();
         to++;
      end
      if (to >= 50) check("ready_timeout", 32'd0, 32'd1);
      tick();
      stream_if.Loader_InValid = 1'b0;
   endtask

   task automatic start_frame();
      Loader_Start = 1'b1;
      tick();
      Loader_Start = 1'b0;
      check("start_busy", Loader_Busy, 1'b1);
      check("start_err_clr", Loader_Error, 1'b0);
      check("start_halt", Cores_Halt, 1'b1);
   endtask

   task automatic run_frame(input vec_t v, input int maxgap, input bit glitch);
      int w0, n;
      logic [CB-1:0] a;
      start_frame();
      w0 = wr_count;
      send(FB'(v.base), $urandom_range(0, maxgap));
      send(FB'(v.len), $urandom_range(0, maxgap));
      for (int i = 0; i <= int'(v.len); i++) begin
         if (glitch && i == 1) begin
            Loader_Start = 1'b1;
            tick();
            Loader_Start = 1'b0;
         end
         send(v.data[i], $urandom_range(0, maxgap));
      end
      check("write_count", wr_count - w0, int'(v.len) + 1);
      Core_InstructionAddr = CB'($urandom);
      send(v.csum, $urandom_range(0, maxgap));
      n = 0;
      while (!(Loader_Done || Loader_Error) && n < 100) begin
         if (n <= int'(v.len)) begin
            a = v.base + CB'(n);
            check("verify_addr", PCRam_InstructionAddr, a);
         end
         tick();
         n++;
      end
      check("end_latency", n, int'(v.len) + 2);
      check("done_pulse", Loader_Done, v.ok);
      check("error_flag", Loader_Error, !v.ok);
      tick();
      check("done_one_cycle", Loader_Done, 1'b0);
      check("idle_busy", Loader_Busy, 1'b0);
      check("halt_after", Cores_Halt, !v.ok);
      check("error_sticky", Loader_Error, !v.ok);
      for (int i = 0; i <= int'(v.len); i++) begin
         a = v.base + CB'(i);
         check("ram_word", mem[a], v.data[i]);
      end
      Core_InstructionAddr = CB'($urandom);
      #1;
      check("idle_mux", PCRam_InstructionAddr, Core_InstructionAddr);
   endtask

   initial begin
      vec_t          tbl [4];
      vec_t          r;
      logic [FB-1:0] sum, pre, d0, d1;
      int            w0;

      tbl[0] = '{base: 6'h05, len: 6'h02, data: 64'h0000_0000_0033_2211, csum: 8'h66, ok: 1'b1};
      tbl[1] = '{base: 6'h3E, len: 6'h03, data: 64'h0000_0000_0403_0201, csum: 8'h0A, ok: 1'b1};
      tbl[2] = '{base: 6'h3E, len: 6'h03, data: 64'h0000_0000_0403_0201, csum: 8'h67, ok: 1'b0};
      tbl[3] = '{base: 6'h05, len: 6'h00, data: 64'h0000_0000_0000_005A, csum: 8'h5A, ok: 1'b1};

      stream_if.Loader_InValid = 1'b0;
      stream_if.Loader_InData  = '0;
      Core_InstructionAddr     = 6'h2A;
      #12;
      check("rst_halt", Cores_Halt, 1'b1);
      check("rst_busy", Loader_Busy, 1'b0);
      check("rst_we", PCRam_WE, 1'b0);
      check("rst_done", Loader_Done, 1'b0);
      check("rst_error", Loader_Error, 1'b0);
      check("rst_mux", PCRam_InstructionAddr, 6'h2A);
      @(negedge CLK);
      RSTn = 1'b1;
      tick();
      Loader_Abort = 1'b1;
      tick();
      Loader_Abort = 1'b0;
      check("abort_idle_ignored", Loader_Error, 1'b0);

      for (int i = 0; i < 4; i++) run_frame(tbl[i], 0, 1'b0);

      // Base-62 frame with random stalls and a stray Start during DATA.
      for (int k = 0; k < 3; k++) run_frame(tbl[1], 5, 1'b1);

      // Abort while the second data word is presented.
      pre = mem[6'h11];
      d0  = 8'hA5;
      d1  = pre ^ 8'hFF;
      start_frame();
      w0 = wr_count;
      send(8'h10, 0);
      send(8'h03, 0);
      send(d0, 0);
      stream_if.Loader_InValid = 1'b1;
      stream_if.Loader_InData  = d1;
      Loader_Abort             = 1'b1;
      #1;
      check("abort_ready", stream_if.Loader_InReady, 1'b0);
      check("abort_we", PCRam_WE, 1'b0);
      tick();
      Loader_Abort             = 1'b0;
      stream_if.Loader_InValid = 1'b0;
      check("abort_err", Loader_Error, 1'b1);
      check("abort_busy1", Loader_Busy, 1'b1);
      tick();
      check("abort_busy2", Loader_Busy, 1'b0);
      check("abort_halt", Cores_Halt, 1'b1);
      check("abort_w0", mem[6'h10], d0);
      check("abort_w1", mem[6'h11], pre);
      check("abort_wcnt", wr_count - w0, 1);

      // Async reset mid-frame leaves the partial write in RAM.
      start_frame();
      send(8'h20, 0);
      send(8'h05, 0);
      send(8'h77, 0);
      #2;
      RSTn = 1'b0;
      #1;
      check("arst_busy", Loader_Busy, 1'b0);
      check("arst_halt", Cores_Halt, 1'b1);
      check("arst_err", Loader_Error, 1'b0);
      check("arst_ram", mem[6'h20], 8'h77);
      @(negedge CLK);
      RSTn = 1'b1;
      tick();

      // Random frames against an arithmetic checksum model.
      for (int k = 0; k < 20; k++) begin
         r.base = CB'($urandom);
         r.len  = CB'($urandom_range(0, 7));
         sum    = '0;
         for (int i = 0; i < 8; i++) begin
            r.data[i] = FB'($urandom);
            if (i <= int'(r.len)) sum = sum + r.data[i];
         end
         r.csum = ($urandom_range(0, 3) != 0) ? sum : sum + FB'($urandom_range(1, 255));
         r.ok   = (r.csum == sum);
         run_frame(r, $urandom_range(0, 3), k[0]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
